// File: rtl/gem_rx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gem_rx_pkg : shared types and status-word layout for the GEM RX frame writer
// Revision   : 1.0
// ---------------------------------------------------------------------------
package gem_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } rx_state_e;

    localparam int C_STATUS_W     = 64;
    localparam int C_GEM_STATUS_W = 45;
    localparam int C_ERR_BIT      = 45;
    localparam int C_OVF_BIT      = 46;
    localparam int C_CNT_LSB      = 48;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [C_STATUS_W-1:0] make_status(
        input logic [C_GEM_STATUS_W-1:0] status,
        input logic                      err,
        input logic                      ovf,
        input logic [15:0]               cnt
    );
        logic [C_STATUS_W-1:0] s;
        s                      = '0;
        s[C_GEM_STATUS_W-1:0]  = status;
        s[C_ERR_BIT]           = err;
        s[C_OVF_BIT]           = ovf;
        s[C_CNT_LSB +: 16]     = cnt;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gem_rx_sdp_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gem_rx_sdp_ram : simple dual-port RAM, one write port, registered read port
// Revision       : 1.0
// ---------------------------------------------------------------------------
module gem_rx_sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write-first on address collision so a show-ahead reader sees fresh data.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= (i_we && (i_waddr == i_raddr)) ? i_wdata : mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/gem_rx_frame_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gem_rx_frame_writer : commits clean GEM RX frames to a buffer, rolls back
//                       bad ones, and streams data plus per-frame status out
// Revision            : 1.0
// ---------------------------------------------------------------------------
module gem_rx_frame_writer
    import gem_rx_pkg::*;
#(
    parameter int DATA_DEPTH   = 1024,
    parameter int STATUS_DEPTH = 16
) (
    input  logic        rx_clock,
    input  logic        rx_reset,
    input  logic        rx_w_wr,
    input  logic [31:0] rx_w_data,
    input  logic        rx_w_sop,
    input  logic        rx_w_eop,
    input  logic [44:0] rx_w_status,
    input  logic        rx_w_err,
    input  logic        rx_w_flush,
    output logic        rx_w_overflow,
    output logic [31:0] m_data_tdata,
    output logic        m_data_tlast,
    output logic        m_data_tvalid,
    input  logic        m_data_tready,
    output logic [63:0] m_status_tdata,
    output logic        m_status_tvalid,
    input  logic        m_status_tready,
    output logic [15:0] dropped_frames
);

    localparam int C_AW  = $clog2(DATA_DEPTH);
    localparam int C_PW  = C_AW + 1;
    localparam int C_SAW = $clog2(STATUS_DEPTH);
    localparam int C_SPW = C_SAW + 1;
    localparam logic [C_PW-1:0]  C_DATA_FULL = C_PW'(DATA_DEPTH);
    localparam logic [C_SPW-1:0] C_STAT_FULL = C_SPW'(STATUS_DEPTH);

    rx_state_e          state_q, state_d;
    logic [C_PW-1:0]    rd_q, rd_d, wc_q, wc_d, ws_q, ws_d;
    logic [15:0]        cnt_q, cnt_d, dropped_q, dropped_d;
    logic [C_SPW-1:0]   sw_q, sw_d, sr_q, sr_d;
    logic               rv_q, rv_d, ov_q, ov_d;
    logic [32:0]        od_q, od_d;

    logic               w_full_ws, w_full_wc, w_st_full, w_end_lost;
    logic               w_dram_we, w_dram_re;
    logic [C_AW-1:0]    w_dram_waddr;
    logic [32:0]        w_dram_wdata, w_dram_rdata;
    logic               w_st_push, w_st_ovf, w_st_pop;
    logic [15:0]        w_st_cnt;
    logic [63:0]        w_st_wdata, w_st_rdata;
    logic               w_pop, w_b_load, w_a_free, w_issue;

    assign w_full_ws = ((ws_q - rd_q) == C_DATA_FULL);
    assign w_full_wc = ((wc_q - rd_q) == C_DATA_FULL);
    assign w_st_full = ((sw_q - sr_q) == C_STAT_FULL);

    // Write-side FSM. w_end_lost marks a frame end that cannot be committed.
    always_comb begin
        state_d      = state_q;
        ws_d         = ws_q;
        wc_d         = wc_q;
        cnt_d        = cnt_q;
        dropped_d    = dropped_q;
        w_dram_we    = 1'b0;
        w_dram_waddr = ws_q[C_AW-1:0];
        w_dram_wdata = {rx_w_eop, rx_w_data};
        w_st_push    = 1'b0;
        w_st_ovf     = 1'b0;
        w_st_cnt     = 16'd0;
        w_end_lost   = 1'b0;

        if (rx_w_flush) begin
            ws_d    = wc_q;
            state_d = ST_IDLE;
        end else if (rx_w_wr) begin
            if (rx_w_sop) begin
                ws_d = wc_q;
                if (w_full_wc) begin
                    state_d    = rx_w_eop ? ST_IDLE : ST_DROP;
                    w_end_lost = rx_w_eop;
                end else begin
                    w_dram_we    = 1'b1;
                    w_dram_waddr = wc_q[C_AW-1:0];
                    cnt_d        = 16'd1;
                    ws_d         = wc_q + C_PW'(1);
                    state_d      = ST_RECV;
                    if (rx_w_eop) begin
                        state_d = ST_IDLE;
                        if (w_st_full) begin
                            ws_d       = wc_q;
                            w_end_lost = 1'b1;
                        end else begin
                            wc_d      = wc_q + C_PW'(1);
                            w_st_push = 1'b1;
                            w_st_cnt  = 16'd1;
                        end
                    end
                end
            end else begin
                case (state_q)
                    ST_RECV: begin
                        if (w_full_ws) begin
                            ws_d       = wc_q;
                            state_d    = rx_w_eop ? ST_IDLE : ST_DROP;
                            w_end_lost = rx_w_eop;
                        end else begin
                            w_dram_we = 1'b1;
                            ws_d      = ws_q + C_PW'(1);
                            cnt_d     = sat_inc16(cnt_q);
                            if (rx_w_eop) begin
                                state_d = ST_IDLE;
                                if (w_st_full) begin
                                    ws_d       = wc_q;
                                    w_end_lost = 1'b1;
                                end else begin
                                    wc_d      = ws_q + C_PW'(1);
                                    w_st_push = 1'b1;
                                    w_st_cnt  = sat_inc16(cnt_q);
                                end
                            end
                        end
                    end
                    ST_DROP: begin
                        if (rx_w_eop) begin
                            state_d    = ST_IDLE;
                            w_end_lost = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // A lost frame gets an overflow entry if there is room, else it is counted.
        if (w_end_lost) begin
            if (!w_st_full) begin
                w_st_push = 1'b1;
                w_st_ovf  = 1'b1;
                w_st_cnt  = 16'd0;
            end else begin
                dropped_d = sat_inc16(dropped_q);
            end
        end
    end

    assign w_st_wdata = make_status(rx_w_status, rx_w_err, w_st_ovf, w_st_cnt);

    // Read side: RAM stage (rv) feeding an output register (ov).
    always_comb begin
        w_pop    = ov_q & m_data_tready;
        w_b_load = ~ov_q | w_pop;
        w_a_free = ~rv_q | w_b_load;
        w_issue  = (rd_q != wc_q) & w_a_free;
        rd_d     = w_issue ? rd_q + C_PW'(1) : rd_q;
        rv_d     = w_issue | (rv_q & ~w_b_load);
        ov_d     = w_b_load ? rv_q : ov_q;
        od_d     = (w_b_load & rv_q) ? w_dram_rdata : od_q;
        w_st_pop = (sw_q != sr_q) & m_status_tready;
        sr_d     = w_st_pop ? sr_q + C_SPW'(1) : sr_q;
        sw_d     = w_st_push ? sw_q + C_SPW'(1) : sw_q;
    end

    always_ff @(posedge rx_clock or posedge rx_reset) begin
        if (rx_reset) begin
            state_q   <= ST_IDLE;
            rd_q      <= '0;
            wc_q      <= '0;
            ws_q      <= '0;
            cnt_q     <= '0;
            dropped_q <= '0;
            sw_q      <= '0;
            sr_q      <= '0;
            rv_q      <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wc_q      <= wc_d;
            ws_q      <= ws_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
            sw_q      <= sw_d;
            sr_q      <= sr_d;
            rv_q      <= rv_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
        end
    end

    gem_rx_sdp_ram #(
        .WIDTH (33),
        .DEPTH (DATA_DEPTH)
    ) u_data_ram (
        .i_clk   (rx_clock),
        .i_we    (w_dram_we),
        .i_waddr (w_dram_waddr),
        .i_wdata (w_dram_wdata),
        .i_re    (w_issue),
        .i_raddr (rd_q[C_AW-1:0]),
        .o_rdata (w_dram_rdata)
    );

    // Status FIFO is show-ahead: the read address tracks the next read pointer.
    gem_rx_sdp_ram #(
        .WIDTH (C_STATUS_W),
        .DEPTH (STATUS_DEPTH)
    ) u_status_ram (
        .i_clk   (rx_clock),
        .i_we    (w_st_push),
        .i_waddr (sw_q[C_SAW-1:0]),
        .i_wdata (w_st_wdata),
        .i_re    (1'b1),
        .i_raddr (sr_d[C_SAW-1:0]),
        .o_rdata (w_st_rdata)
    );

    assign w_dram_re       = w_issue;
    assign rx_w_overflow   = (state_q == ST_DROP);
    assign m_data_tdata    = od_q[31:0];
    assign m_data_tlast    = od_q[32];
    assign m_data_tvalid   = ov_q;
    assign m_status_tdata  = w_st_rdata;
    assign m_status_tvalid = (sw_q != sr_q);
    assign dropped_frames  = dropped_q;

    logic w_unused;
    assign w_unused = w_dram_re;

endmodule
`default_nettype wire
